// File: rtl/trdb_pkg.sv
// Shared types for the trace debug controller: FSM states, packet request kinds
// and the registered output bundle.
package trdb_pkg;

    localparam int unsigned RESYNC_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        OFF        = 3'd0,
        START_REQ  = 3'd1,
        ON         = 3'd2,
        RESYNC_REQ = 3'd3,
        STOP_REQ   = 3'd4
    } trace_state_e;

    typedef enum logic [1:0] {
        PKT_START  = 2'd0,
        PKT_STOP   = 2'd1,
        PKT_RESYNC = 2'd2
    } pkt_req_e;

    // Output bundle held in flops next to the state register
    typedef struct packed {
        logic     valid;
        pkt_req_e kind;
        logic     enable;
    } ctrl_out_t;

    // Moore decode of the outputs belonging to a given state
    function automatic ctrl_out_t decode_outputs(input trace_state_e st);
        ctrl_out_t o;
        o.valid  = 1'b0;
        o.kind   = PKT_START;
        o.enable = (st != OFF);
        case (st)
            START_REQ:  begin o.valid = 1'b1; o.kind = PKT_START;  end
            RESYNC_REQ: begin o.valid = 1'b1; o.kind = PKT_RESYNC; end
            STOP_REQ:   begin o.valid = 1'b1; o.kind = PKT_STOP;   end
            default:    ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/trdb_resync_cnt.sv
// Saturating retired-instruction counter used to pace resync packets.
module trdb_resync_cnt
    import trdb_pkg::*;
#(
    parameter int unsigned W = RESYNC_W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear,
    input  logic         inc,
    input  logic         hold,
    input  logic [W-1:0] max,
    output logic         ge_max_c
);

    logic [W-1:0] cnt_q;

    // Clear wins; otherwise count up unless held or already saturated
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && !hold && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // A zero threshold disables resync entirely
    assign ge_max_c = (max != '0) && (cnt_q >= max);

endmodule

// File: rtl/trdb_trace_ctrl.sv
// Trace session sequencer: qualifies trace_enable and requests start, stop and
// periodic resync packets from the packet emitter over valid/ready.
module trdb_trace_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned RESYNC_W = RESYNC_W_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trace_activated_i,
    input  logic                trace_req_on_i,
    input  logic                trace_req_off_i,
    input  logic                inst_valid_i,
    input  logic [RESYNC_W-1:0] resync_max_i,
    input  logic                pkt_ready_i,
    output logic                pkt_req_valid_o,
    output logic [1:0]          pkt_req_type_o,
    output logic                trace_enable_o,
    output logic [2:0]          state_o
);

    trace_state_e state_q, state_d;
    logic         stop_pend_q, stop_pend_d;
    ctrl_out_t    out_q;
    logic         accept;
    logic         cnt_clear, cnt_inc, cnt_hold, ge_max_c;

    assign accept = out_q.valid && pkt_ready_i;

    trdb_resync_cnt #(
        .W (RESYNC_W)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .hold     (cnt_hold),
        .max      (resync_max_i),
        .ge_max_c (ge_max_c)
    );

    // Next-state, pending-stop and counter control
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        cnt_hold    = 1'b0;
        if ((state_q != OFF) && !trace_activated_i) begin
            // Master enable dropped: abandon the session without a packet
            state_d     = OFF;
            stop_pend_d = 1'b0;
            cnt_clear   = 1'b1;
        end else begin
            case (state_q)
                OFF: begin
                    if (trace_activated_i && trace_req_on_i && !trace_req_off_i) begin
                        state_d = START_REQ;
                    end
                end
                START_REQ: begin
                    if (accept) begin
                        cnt_clear = 1'b1;
                        state_d   = stop_pend_q ? STOP_REQ : ON;
                    end else if (trace_req_off_i) begin
                        stop_pend_d = 1'b1;
                    end
                end
                ON: begin
                    cnt_inc = inst_valid_i;
                    if (trace_req_off_i) begin
                        state_d = STOP_REQ;
                    end else if (ge_max_c) begin
                        state_d = RESYNC_REQ;
                    end
                end
                RESYNC_REQ: begin
                    cnt_hold = 1'b1;
                    if (accept) begin
                        cnt_clear = 1'b1;
                        state_d   = (stop_pend_q || trace_req_off_i) ? STOP_REQ : ON;
                    end else if (trace_req_off_i) begin
                        stop_pend_d = 1'b1;
                    end
                end
                STOP_REQ: begin
                    if (accept) begin
                        state_d     = OFF;
                        stop_pend_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = OFF;
                    stop_pend_d = 1'b0;
                    cnt_clear   = 1'b1;
                end
            endcase
        end
    end

    // State register with outputs registered alongside it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= OFF;
            stop_pend_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            out_q       <= decode_outputs(state_d);
        end
    end

    assign pkt_req_valid_o = out_q.valid;
    assign pkt_req_type_o  = out_q.kind;
    assign trace_enable_o  = out_q.enable;
    assign state_o         = state_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Directed self-checking bench for trdb_trace_ctrl.
module tb_trdb_trace_ctrl;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_ON     = 3'd2;
    localparam logic [2:0] S_RESYNC = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [1:0] T_START  = 2'd0;
    localparam logic [1:0] T_STOP   = 2'd1;
    localparam logic [1:0] T_RESYNC = 2'd2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        trace_activated_i;
    logic        trace_req_on_i;
    logic        trace_req_off_i;
    logic        inst_valid_i;
    logic [15:0] resync_max_i;
    logic        pkt_ready_i;
    logic        pkt_req_valid_o;
    logic [1:0]  pkt_req_type_o;
    logic        trace_enable_o;
    logic [2:0]  state_o;

    int total = 0;
    int bad   = 0;

    trdb_trace_ctrl #(.RESYNC_W(16)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .trace_activated_i (trace_activated_i),
        .trace_req_on_i    (trace_req_on_i),
        .trace_req_off_i   (trace_req_off_i),
        .inst_valid_i      (inst_valid_i),
        .resync_max_i      (resync_max_i),
        .pkt_ready_i       (pkt_ready_i),
        .pkt_req_valid_o   (pkt_req_valid_o),
        .pkt_req_type_o    (pkt_req_type_o),
        .trace_enable_o    (trace_enable_o),
        .state_o           (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare the full observable output set
    task automatic chk_all(input string tag, input logic [2:0] st, input logic v,
                           input logic [1:0] ty, input logic en);
        chk({tag, ".state"},  32'(state_o),         32'(st));
        chk({tag, ".valid"},  32'(pkt_req_valid_o), 32'(v));
        chk({tag, ".type"},   32'(pkt_req_type_o),  32'(ty));
        chk({tag, ".enable"}, 32'(trace_enable_o),  32'(en));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Pulse req_on for one sampled edge; leaves the FSM in START_REQ
    task automatic start_session(input string tag);
        trace_req_on_i = 1'b1;
        tick();
        trace_req_on_i = 1'b0;
        chk_all({tag, ".start"}, S_START, 1'b1, T_START, 1'b1);
    endtask

    initial begin
        rst_ni            = 1'b0;
        trace_activated_i = 1'b0;
        trace_req_on_i    = 1'b0;
        trace_req_off_i   = 1'b0;
        inst_valid_i      = 1'b0;
        resync_max_i      = 16'd0;
        pkt_ready_i       = 1'b1;
        #2;
        chk_all("reset", S_OFF, 1'b0, T_START, 1'b0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        chk_all("post_reset", S_OFF, 1'b0, T_START, 1'b0);

        // Not activated: req_on is ignored
        trace_req_on_i = 1'b1;
        tick();
        trace_req_on_i = 1'b0;
        chk_all("inactive_on", S_OFF, 1'b0, T_START, 1'b0);

        // Basic session
        trace_activated_i = 1'b1;
        start_session("basic");
        tick();
        chk_all("basic.on", S_ON, 1'b0, T_START, 1'b1);
        trace_req_on_i = 1'b1;
        tick(); tick();
        trace_req_on_i = 1'b0;
        chk_all("basic.on_ignored", S_ON, 1'b0, T_START, 1'b1);
        trace_req_off_i = 1'b1;
        tick();
        trace_req_off_i = 1'b0;
        chk_all("basic.stop", S_STOP, 1'b1, T_STOP, 1'b1);
        tick();
        chk_all("basic.off", S_OFF, 1'b0, T_START, 1'b0);

        // on and off together: off wins
        trace_req_on_i  = 1'b1;
        trace_req_off_i = 1'b1;
        tick();
        trace_req_on_i  = 1'b0;
        trace_req_off_i = 1'b0;
        chk_all("on_off_both", S_OFF, 1'b0, T_START, 1'b0);

        // Resync every 4 instructions: 5 ON cycles (count 0..4) then RESYNC_REQ
        resync_max_i = 16'd4;
        inst_valid_i = 1'b1;
        start_session("resync");
        tick();
        chk_all("resync.on0", S_ON, 1'b0, T_START, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk($sformatf("resync.r%0d.on%0d", r, k), 32'(state_o), 32'(S_ON));
            end
            tick();
            chk_all($sformatf("resync.r%0d.req", r), S_RESYNC, 1'b1, T_RESYNC, 1'b1);
            tick();
            chk_all($sformatf("resync.r%0d.back", r), S_ON, 1'b0, T_START, 1'b1);
        end
        // Threshold zero: never resync
        resync_max_i = 16'd0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("nores.%0d", k), 32'(state_o), 32'(S_ON));
        end
        // Count is now 12; lowering the threshold below it fires on the next ON edge
        resync_max_i = 16'd3;
        tick();
        chk_all("lower_max", S_RESYNC, 1'b1, T_RESYNC, 1'b1);
        resync_max_i = 16'd0;
        tick();
        chk("lower_max.back", 32'(state_o), 32'(S_ON));
        trace_req_off_i = 1'b1;
        tick();
        trace_req_off_i = 1'b0;
        chk_all("resync.stop", S_STOP, 1'b1, T_STOP, 1'b1);
        tick();
        chk_all("resync.off", S_OFF, 1'b0, T_START, 1'b0);

        // Backpressure in START_REQ with off during the stall
        pkt_ready_i = 1'b0;
        start_session("bp");
        for (int i = 0; i < 10; i++) begin
            trace_req_off_i = (i == 3);
            tick();
            chk_all($sformatf("bp.stall%0d", i), S_START, 1'b1, T_START, 1'b1);
        end
        trace_req_off_i = 1'b0;
        pkt_ready_i     = 1'b1;
        tick();
        chk_all("bp.stop", S_STOP, 1'b1, T_STOP, 1'b1);
        tick();
        chk_all("bp.off", S_OFF, 1'b0, T_START, 1'b0);

        // off on the same edge that would trigger resync: stop wins
        resync_max_i = 16'd4;
        start_session("prio");
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("prio.on", 32'(state_o), 32'(S_ON));
        trace_req_off_i = 1'b1;
        tick();
        trace_req_off_i = 1'b0;
        chk_all("prio.stop", S_STOP, 1'b1, T_STOP, 1'b1);
        tick();
        chk("prio.off", 32'(state_o), 32'(S_OFF));

        // Abort during a stalled RESYNC_REQ
        resync_max_i = 16'd2;
        start_session("abort");
        tick();
        tick(); tick();
        pkt_ready_i = 1'b0;
        tick();
        chk_all("abort.resync", S_RESYNC, 1'b1, T_RESYNC, 1'b1);
        tick();
        chk_all("abort.stall", S_RESYNC, 1'b1, T_RESYNC, 1'b1);
        trace_activated_i = 1'b0;
        tick();
        chk_all("abort.off", S_OFF, 1'b0, T_START, 1'b0);
        chk("abort.cnt", 32'(dut.u_cnt.cnt_q), 32'd0);
        inst_valid_i      = 1'b0;
        resync_max_i      = 16'd0;
        trace_activated_i = 1'b1;
        start_session("restart");

        // Async reset mid STOP_REQ
        pkt_ready_i = 1'b1;
        tick();
        chk("restart.on", 32'(state_o), 32'(S_ON));
        pkt_ready_i     = 1'b0;
        trace_req_off_i = 1'b1;
        tick();
        trace_req_off_i = 1'b0;
        tick();
        chk_all("rst.stop", S_STOP, 1'b1, T_STOP, 1'b1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_all("rst.async", S_OFF, 1'b0, T_START, 1'b0);
        tick();
        #2;
        rst_ni      = 1'b1;
        pkt_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("rst.after%0d", k), S_OFF, 1'b0, T_START, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trdb_trace_ctrl.md
Name: trdb_trace_ctrl

Overview:
Sequences trace sessions for the encoder. It turns trigger and filter on/off requests into a qualified trace_enable and asks the packet emitter for start, stop and periodic resync packets over a valid/ready handshake. It sits between the trigger unit, the filter, the register block (trace_activated, resync threshold) and the packet emitter.

Parameters:
RESYNC_W, 16, width of the resync instruction counter and of resync_max_i

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
trace_activated_i  in  1  user master enable from register block
trace_req_on_i  in  1  start request from trigger unit, level, sampled each cycle
trace_req_off_i  in  1  stop request from filter, level, sampled each cycle
inst_valid_i  in  1  one retired instruction this cycle
resync_max_i  in  RESYNC_W  instructions between resync packets; 0 disables resync
pkt_ready_i  in  1  packet emitter accepts request
pkt_req_valid_o  out  1  packet request valid
pkt_req_type_o  out  2  trdb_pkg::pkt_req_e: START=0, STOP=1, RESYNC=2
trace_enable_o  out  1  encoder tracing enabled
state_o  out  3  current FSM state, for debug

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low. Reset: state OFF, counter 0, stop_pending 0; all outputs 0 (state_o=OFF).
- Moore FSM; outputs decode from the registered state only.
- Valid outputs: pkt_req_valid_o=1 in START_REQ, RESYNC_REQ and STOP_REQ. trace_enable_o=1 in every state except OFF.
- Handshake: accept = valid && pkt_ready_i. While valid is high and not yet accepted, type stays stable. The only exception is the trace_activated_i abort.
- OFF → START_REQ when trace_activated_i && trace_req_on_i && !trace_req_off_i. If on and off are both high, off wins and the FSM stays OFF. Latency: request at cycle N, valid and enable high at N+1.
- START_REQ:
  - accept → ON and clear the counter.
  - trace_req_off_i before accept → set stop_pending; after accept go to STOP_REQ.
- ON:
  - Counter increments on inst_valid_i and saturates at all-ones.
  - trace_req_off_i → STOP_REQ. This has priority over resync in the same cycle.
  - Otherwise, if resync_max_i != 0 and counter >= resync_max_i → RESYNC_REQ.
  - trace_req_on_i is ignored.
- RESYNC_REQ:
  - Counter holds.
  - accept → clear the counter; go to STOP_REQ if stop_pending (or trace_req_off_i this cycle), else ON.
  - trace_req_off_i before accept → set stop_pending.
- STOP_REQ: accept → OFF and clear stop_pending. trace_enable_o falls the cycle after accept.
- Any state except OFF, trace_activated_i=0 → OFF next cycle. No packet is sent, any pending request is dropped, and counter and stop_pending clear.
- Reset mid-handshake: valid drops asynchronously and the emitter discards the request.
- Counter compare is unsigned, full RESYNC_W width. Lowering resync_max_i below the current count triggers resync on the next ON cycle.
- A single pulse of trace_req_on_i in OFF is enough to start; on is not latched, so it must be sampled high for at least one OFF cycle.

Decomposition:
- trdb_pkg holds:
  - typedef enum logic [2:0] trace_state_e {OFF, START_REQ, ON, RESYNC_REQ, STOP_REQ}
  - typedef enum logic [1:0] pkt_req_e {PKT_START, PKT_STOP, PKT_RESYNC}
  - localparam RESYNC_W_DEFAULT = 16
- Sub-module trdb_resync_cnt: saturating counter with inputs clear, inc and hold, and output ge_max. The FSM stays in trdb_trace_ctrl.

Test Plan:
- Basic session:
  - Stimulus: activated=1, req_on pulse at cycle 5, pkt_ready=1.
  - Response: valid=1 with type START at cycle 6, enable=1 from cycle 6, ON at cycle 7.
  - Then req_off at cycle 20 → type STOP at cycle 21, OFF at cycle 22, enable=0 from cycle 22.
- Resync:
  - Stimulus: resync_max=4, inst_valid every cycle while ON, pkt_ready=1.
  - Response: RESYNC request after the 4th instruction, counter back to 0 after accept, repeating every 4 instructions; resync_max=0 → no RESYNC ever.
- Backpressure:
  - Stimulus: pkt_ready=0 for 10 cycles during START_REQ, with req_off asserted at cycle 3 of the stall.
  - Response: type stays START throughout; after accept, STOP_REQ immediately, then OFF.
- Simultaneous requests:
  - Stimulus: req_on=req_off=1 in OFF → stays OFF.
  - Stimulus: req_off in the same cycle the count reaches resync_max → STOP_REQ, not RESYNC_REQ.
- Abort:
  - Stimulus: activated drops during RESYNC_REQ with pkt_ready=0.
  - Response: valid=0 and OFF next cycle, counter=0; a later req_on restarts with START.
- Reset:
  - Stimulus: assert rst_ni low mid-STOP_REQ, asynchronously between clock edges.
  - Response: all outputs 0 immediately; after release stays OFF with no spurious valid.
